// File: rtl/booth_mult_r4.sv
// booth_mult_r4 -- iterative radix-4 Booth multiplier.
//
// Retires two multiplier bits per clock. Operands are widened by two bits
// (sign- or zero-extended according to is_signed) so that one recoding
// datapath covers both the signed and the unsigned case. With the extended
// width EW = WIDTH+2, the EW/2 = WIDTH/2+1 iterations consume the whole
// extended multiplier.
//
// Parameters:
//   WIDTH         operand width (even, >= 4); product is 2*WIDTH bits
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset; aborts any operation
//   start         request, accepted only while busy = 0
//   is_signed     1 = two's-complement operands, 0 = unsigned
//   multiplier    operand Q, captured with start
//   multiplicand  operand M, captured with start
//   busy          high while an operation is in progress
//   done          one-cycle pulse when result has just been updated
//   result        product, held until the next completion
module booth_mult_r4 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int EW    = WIDTH + 2;      // extended operand width
  localparam int NITER = WIDTH / 2 + 1;  // iterations per operation
  localparam int CW    = $clog2(NITER + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg;
  // Accumulator is {hi_reg, lo_reg, qm1_reg}. lo_reg starts as the extended
  // multiplier and fills with product bits from the top as it shifts out.
  // hi_reg carries two guard bits so hi + (+/-2M) never overflows.
  logic signed [EW+1:0]   hi_reg;
  logic [EW-1:0]          lo_reg;
  logic                   qm1_reg;
  logic [EW-1:0]          m_reg;
  logic [2*WIDTH-1:0]     result_reg;
  logic                   done_reg;

  logic signed [EW+1:0]   m_ext;
  logic signed [EW+1:0]   term;
  logic signed [EW+1:0]   sum;
  logic signed [EW+1:0]   hi_next;
  logic [EW-1:0]          lo_next;
  logic                   accept;
  logic                   last;
  logic                   q_ext_bit;
  logic                   m_ext_bit;

  assign accept    = (state_reg == IDLE) && start;
  assign last      = (state_reg == RUN) && (cnt_reg == CW'(1));
  assign q_ext_bit = is_signed & multiplier[WIDTH-1];
  assign m_ext_bit = is_signed & multiplicand[WIDTH-1];

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == CW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One Booth step: recode the low triple, add into the upper half,
  // then arithmetic-shift the whole accumulator right by two.
  always_comb begin
    m_ext = {{2{m_reg[EW-1]}}, m_reg};
    term  = '0;
    case ({lo_reg[1:0], qm1_reg})
      3'b001, 3'b010: term = m_ext;
      3'b011:         term = m_ext <<< 1;
      3'b100:         term = -(m_ext <<< 1);
      3'b101, 3'b110: term = -m_ext;
      default:        term = '0;
    endcase
    sum     = hi_reg + term;
    hi_next = sum >>> 2;
    lo_next = {sum[1:0], lo_reg[EW-1:2]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      qm1_reg    <= 1'b0;
      m_reg      <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      if (accept) begin
        m_reg   <= {{2{m_ext_bit}}, multiplicand};
        lo_reg  <= {{2{q_ext_bit}}, multiplier};
        hi_reg  <= '0;
        qm1_reg <= 1'b0;
        cnt_reg <= CW'(NITER);
      end else if (state_reg == RUN) begin
        hi_reg  <= hi_next;
        lo_reg  <= lo_next;
        qm1_reg <= lo_reg[1];
        cnt_reg <= cnt_reg - CW'(1);
        if (last) begin
          // The true product always fits in 2*WIDTH bits, so the low
          // slice of the extended product is exact in both modes.
          result_reg <= {hi_next[WIDTH-3:0], lo_next};
          done_reg   <= 1'b1;
        end
      end
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_booth_mult_r4.sv
// tb_booth_mult_r4 -- directed and swept checks of booth_mult_r4 at
// WIDTH = 8 (main instance), 4 and 16.
module tb_booth_mult_r4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start8, sg8, busy8, done8;
  logic [7:0]  q8, m8;
  logic [15:0] res8;

  logic        start4, sg4, busy4, done4;
  logic [3:0]  q4, m4;
  logic [7:0]  res4;

  logic        start16, sg16, busy16, done16;
  logic [15:0] q16, m16;
  logic [31:0] res16;

  int n_checks = 0;
  int n_fail   = 0;

  booth_mult_r4 #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sg8),
    .multiplier(q8), .multiplicand(m8),
    .busy(busy8), .done(done8), .result(res8)
  );

  booth_mult_r4 #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .is_signed(sg4),
    .multiplier(q4), .multiplicand(m4),
    .busy(busy4), .done(done4), .result(res4)
  );

  booth_mult_r4 #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .is_signed(sg16),
    .multiplier(q16), .multiplicand(m16),
    .busy(busy16), .done(done16), .result(res16)
  );

  // Issue one WIDTH=8 operation; return result at the done cycle, latency
  // in cycles after the start edge (-1 on timeout) and busy-cycle count.
  task automatic run8(input logic s, input logic [7:0] q, input logic [7:0] m,
                      output logic [15:0] r, output int lat, output int bcnt);
    @(negedge clk);
    start8 = 1'b1; sg8 = s; q8 = q; m8 = m;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    bcnt = busy8 ? 1 : 0;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy8) bcnt++;
      if (done8) begin
        lat = c;
        break;
      end
    end
    r = res8;
    $display("w8  s=%0d q=%h m=%h -> result=%h latency=%0d", s, q, m, r, lat);
  endtask

  task automatic run4(input logic s, input logic [3:0] q, input logic [3:0] m,
                      output logic [7:0] r, output int lat);
    @(negedge clk);
    start4 = 1'b1; sg4 = s; q4 = q; m4 = m;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done4) begin
        lat = c;
        break;
      end
    end
    r = res4;
    $display("w4  s=%0d q=%h m=%h -> result=%h latency=%0d", s, q, m, r, lat);
  endtask

  task automatic run16(input logic s, input logic [15:0] q, input logic [15:0] m,
                       output logic [31:0] r, output int lat);
    @(negedge clk);
    start16 = 1'b1; sg16 = s; q16 = q; m16 = m;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done16) begin
        lat = c;
        break;
      end
    end
    r = res16;
    $display("w16 s=%0d q=%h m=%h -> result=%h latency=%0d", s, q, m, r, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_w8: busy=%b done=%b result=%h, required 0 0 0000", busy8, done8, res8);
    end
    n_checks++;
    if (busy4 !== 1'b0 || busy16 !== 1'b0 || res4 !== 8'h00 || res16 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_w4_w16: busy4=%b busy16=%b res4=%h res16=%h, required zeros",
               busy4, busy16, res4, res16);
    end
  endtask

  task automatic test_basic();
    logic [15:0] r;
    int lat, bcnt;
    run8(1'b1, 8'h55, 8'h05, r, lat, bcnt);
    n_checks++;
    if (r !== 16'h01A9) begin
      n_fail++;
      $display("FAIL basic_result: got %h, required 01a9", r);
    end
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, required 5", lat);
    end
    n_checks++;
    if (bcnt != 5) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d, required 5", bcnt);
    end
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || res8 !== 16'h01A9) begin
      n_fail++;
      $display("FAIL basic_after_done: done=%b busy=%b result=%h, required 0 0 01a9", done8, busy8, res8);
    end
  endtask

  // Table entries: {is_signed, Q, M, expected product}
  task automatic test_products();
    bit [32:0] tbl [12];
    logic [15:0] r;
    int lat, bcnt;
    tbl = '{
      {1'b1, 8'hD5, 8'h05, 16'hFF29},
      {1'b1, 8'h00, 8'h95, 16'h0000},
      {1'b1, 8'h95, 8'h00, 16'h0000},
      {1'b1, 8'h80, 8'h80, 16'h4000},
      {1'b1, 8'h81, 8'h7F, 16'hC0FF},
      {1'b1, 8'h7F, 8'h7F, 16'h3F01},
      {1'b1, 8'hFF, 8'hFF, 16'h0001},
      {1'b0, 8'hFF, 8'hFF, 16'hFE01},
      {1'b0, 8'h81, 8'h7F, 16'h3FFF},
      {1'b0, 8'hD5, 8'h05, 16'h0429},
      {1'b0, 8'h80, 8'h80, 16'h4000},
      {1'b1, 8'h05, 8'hD5, 16'hFF29}
    };
    for (int i = 0; i < 12; i++) begin
      run8(tbl[i][32], tbl[i][31:24], tbl[i][23:16], r, lat, bcnt);
      n_checks++;
      if (r !== tbl[i][15:0] || lat != 5) begin
        n_fail++;
        $display("FAIL product_%0d: result=%h latency=%0d, required %h latency 5",
                 i, r, lat, tbl[i][15:0]);
      end
    end
  endtask

  // Start pulsed mid-run plus operand changes after capture: both ignored.
  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    start8 = 1'b1; sg8 = 1'b1; q8 = 8'h55; m8 = 8'h05;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        lat = c;
        break;
      end
      if (c == 1) begin
        start8 = 1'b1; sg8 = 1'b0; q8 = 8'hFF; m8 = 8'hFF;
      end
      if (c == 2) begin
        start8 = 1'b0; q8 = 8'h13; m8 = 8'hA7;
      end
    end
    $display("w8  mid-run start ignored -> result=%h latency=%0d", res8, lat);
    n_checks++;
    if (res8 !== 16'h01A9 || lat != 5) begin
      n_fail++;
      $display("FAIL start_ignored: result=%h latency=%0d, required 01a9 latency 5", res8, lat);
    end
    @(negedge clk);
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL start_not_queued: busy=%b, required 0", busy8);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    int lat, bcnt, gap;
    run8(1'b1, 8'h7F, 8'h7F, r, lat, bcnt);
    // Still in the done cycle: issue the next operation now.
    start8 = 1'b1; sg8 = 1'b1; q8 = 8'h81; m8 = 8'h7F;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1 || res8 !== 16'h3F01) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b result=%h, required 1 3f01", busy8, res8);
    end
    gap = -1;
    for (int c = 2; c <= 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        gap = c;
        break;
      end
    end
    $display("w8  back-to-back second op -> result=%h gap=%0d", res8, gap);
    n_checks++;
    if (gap != 6 || res8 !== 16'hC0FF) begin
      n_fail++;
      $display("FAIL b2b_second: gap=%0d result=%h, required gap 6 result c0ff", gap, res8);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] r;
    int lat, bcnt, stray;
    @(negedge clk);
    start8 = 1'b1; sg8 = 1'b1; q8 = 8'h55; m8 = 8'h05;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("w8  reset at iteration 3 -> busy=%b done=%b result=%h", busy8, done8, res8);
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b result=%h, required 0 0 0000", busy8, done8, res8);
    end
    stray = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done8 || busy8) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d active cycles after abort, required 0", stray);
    end
    // Start on the same edge as reset is dropped.
    reset = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_start: busy=%b, required 0", busy8);
    end
    run8(1'b0, 8'hFF, 8'hFF, r, lat, bcnt);
    n_checks++;
    if (r !== 16'hFE01 || lat != 5) begin
      n_fail++;
      $display("FAIL after_reset_op: result=%h latency=%0d, required fe01 latency 5", r, lat);
    end
  endtask

  task automatic test_sweep_w4();
    logic [3:0] a, b;
    logic [7:0] r, exp;
    logic s;
    int lat;
    longint sa, sb;
    for (int i = 0; i < 40; i++) begin
      s = i[0];
      a = 4'($urandom);
      b = 4'($urandom);
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      exp = 8'(sa * sb);
      run4(s, a, b, r, lat);
      n_checks++;
      if (r !== exp || lat != 3) begin
        n_fail++;
        $display("FAIL sweep_w4: s=%0d %h*%h result=%h latency=%0d, required %h latency 3",
                 s, a, b, r, lat, exp);
      end
    end
  endtask

  task automatic test_sweep_w16();
    logic [15:0] a, b;
    logic [31:0] r, exp;
    logic s;
    int lat;
    longint sa, sb;
    for (int i = 0; i < 40; i++) begin
      s = i[0];
      a = 16'($urandom);
      b = 16'($urandom);
      if (i < 2) begin
        a = 16'h8000;
        b = 16'hFFFF;
      end
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      exp = 32'(sa * sb);
      run16(s, a, b, r, lat);
      n_checks++;
      if (r !== exp || lat != 9) begin
        n_fail++;
        $display("FAIL sweep_w16: s=%0d %h*%h result=%h latency=%0d, required %h latency 9",
                 s, a, b, r, lat, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0; sg8 = 1'b0; q8 = '0; m8 = '0;
    start4 = 1'b0; sg4 = 1'b0; q4 = '0; m4 = '0;
    start16 = 1'b0; sg16 = 1'b0; q16 = '0; m16 = '0;
    test_reset();
    test_basic();
    test_products();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep_w4();
    test_sweep_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult_r4.md
# booth_mult_r4

Parametrised radix-4 Booth multiplier: the multi-cycle successor to the 8-bit radix-2 `booth_mult`, generalised to any even operand width. It adds a run-time signed/unsigned mode and a start/busy/done handshake, and retires two multiplier bits per cycle. It sits in the datapath as a shared iterative multiplier, driven by a controller that issues one operation at a time and samples the result on `done`.

## Interface
Parameters:
- `WIDTH`, default 8: operand width; must be even and ≥ 4; result width is 2*WIDTH.

Ports:
- `clk`  in  1  rising-edge clock; sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled on the rising edge; accepted only when `busy`=0.
- `is_signed`  in  1  1 = two's-complement operands; 0 = unsigned operands; sampled with `start`.
- `multiplier`  in  WIDTH  operand Q; sampled with `start`.
- `multiplicand`  in  WIDTH  operand M; sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse: `result` has just been updated.
- `result`  out  2*WIDTH  product; holds its value until the next completion.

## Operation
- States: IDLE, RUN.
  - IDLE → RUN on an accepted `start`.
  - RUN → IDLE after N = WIDTH/2 + 1 iterations.
- Capture (accepted `start`):
  - Extend M and Q to WIDTH+2 bits: sign-extend if `is_signed`=1, else zero-extend.
  - Clear the accumulator, set the appended bit q[-1] to 0, load the iteration counter with N.
- Iteration i (0..N-1):
  - Examine the triple {q[2i+1], q[2i], q[2i-1]}.
  - Recode: 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → -2M; 101/110 → -M.
  - Add the selected term into the upper half of the accumulator, then arithmetic-shift the accumulator right by 2.
  - Accumulator width: 2*(WIDTH+2)+1 bits, sufficient to avoid overflow of ±2M.
- Completion: `result` = low 2*WIDTH bits of the final product. This is exact in both modes, because the true product always fits in 2*WIDTH bits (signed or unsigned).
- Operand inputs may change freely after capture; they do not affect an operation in flight.
- `start` while `busy`=1: ignored. There is no queueing, and the in-flight operation is unaffected.
- `reset`=1 at any edge, including mid-RUN:
  - Aborts the operation and goes to IDLE.
  - `busy`=0, `done`=0, `result`=0.
  - A `start` presented on the same edge as `reset` is dropped.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE.
- `start` accepted at edge k:
  - `busy`=1 from after edge k.
  - Iterations occur on edges k+1 … k+N.
- At edge k+N:
  - `result` updated, `done`=1 for exactly one cycle, `busy`=0.
  - Latency start→done = N cycles (WIDTH=8: N=5).
- Back-to-back: a `start` in the cycle where `done`=1 is accepted (`busy` is already 0), so throughput is one operation per N+1 cycles.
- `result` changes only at a completion edge or on reset; it is stable for the full cycle `done` is high and thereafter.
- `is_signed` affects only the operation it was captured with.

## Test plan
1. Reset, then with WIDTH=8: signed Q=0x55, M=0x05 → `done` exactly 5 cycles after the start edge, `result`=0x01A9 (425), `busy` high for exactly 5 cycles.
2. Signed mode, mixed signs and zero: 0xD5×0x05 → 0xFF29 (-215); 0x00×0x95 → 0x0000; 0x95×0x00 → 0x0000.
3. Extremes:
   - signed 0x80×0x80 → 0x4000;
   - signed 0x81×0x7F → 0xC0FF (-16129);
   - signed 0x7F×0x7F → 0x3F01;
   - signed 0xFF×0xFF → 0x0001;
   - unsigned 0xFF×0xFF → 0xFE01;
   - unsigned 0x81×0x7F → 0x3FFF.
4. Handshake:
   - `start` pulsed mid-RUN with different operands → ignored, original product delivered;
   - new `start` in the `done` cycle → accepted, second `done` N+1 cycles after the first;
   - operands changed after capture → no effect.
5. Reset mid-operation: assert `reset` at iteration 3 → next cycle `busy`=0, `done`=0, `result`=0, and no `done` pulse follows; a subsequent start completes normally.
6. Parameter sweep WIDTH=4, 16: randomised signed and unsigned operands checked against a reference product; latency = WIDTH/2+1 cycles.
